ks_wide_seq_adder: RTL and testbench

KS_WIDE_SEQ_ADDER -- requirements
Module: ks_wide_seq_adder

---
 rtl/ks_pkg.sv | 16 +
 rtl/ks_add16.sv | 39 +++
 rtl/ks_wide_seq_adder.sv | 116 +++++++++++
 tb/tb_ks_wide_seq_adder.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/ks_pkg.sv
// Shared constants, FSM state type and sizing helper for the sequential wide adder.
package ks_pkg;

    localparam int SLICE_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ks_add16.sv
// 16-bit Kogge-Stone adder with carry-in, purely combinational.
import ks_pkg::*;

module ks_add16 (
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               cout
);

    localparam int LEVELS = $clog2(SLICE_W);

    logic [LEVELS:0][SLICE_W-1:0] g;
    logic [LEVELS:0][SLICE_W-1:0] p;
    logic [SLICE_W-1:0]           c;

    assign g[0] = a & b;
    assign p[0] = a ^ b;

    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        localparam int D = 1 << l;
        for (genvar i = 0; i < SLICE_W; i++) begin : g_bit
            if (i >= D) begin : g_op
                assign g[l+1][i] = g[l][i] | (p[l][i] & g[l][i-D]);
                assign p[l+1][i] = p[l][i] & p[l][i-D];
            end else begin : g_pass
                assign g[l+1][i] = g[l][i];
                assign p[l+1][i] = p[l][i];
            end
        end
    end

    // Group terms span bit 0 upward, so folding cin in gives every carry directly.
    assign c    = g[LEVELS] | (p[LEVELS] & {SLICE_W{cin}});
    assign sum  = p[0] ^ {c[SLICE_W-2:0], cin};
    assign cout = c[SLICE_W-1];

endmodule

// File: rtl/ks_wide_seq_adder.sv
// Wide adder processing one 16-bit slice per cycle through a shared Kogge-Stone core.
// Optional macro KS_WIDE_CIN_EN adds a cin port used as slice-0 carry-in.
import ks_pkg::*;

module ks_wide_seq_adder #(
    parameter int NUM_SLICES = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [SLICE_W*NUM_SLICES-1:0] a,
    input  logic [SLICE_W*NUM_SLICES-1:0] b,
`ifdef KS_WIDE_CIN_EN
    input  logic                          cin,
`endif
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [SLICE_W*NUM_SLICES-1:0] sum,
    output logic                          cout
);

    localparam int W  = SLICE_W * NUM_SLICES;
    localparam int CW = cnt_width(NUM_SLICES);

    state_t               state;
    logic [W-1:0]         a_r;
    logic [W-1:0]         b_r;
    logic [CW-1:0]        cnt;
    logic                 carry;
    logic [SLICE_W-1:0]   a_sl;
    logic [SLICE_W-1:0]   b_sl;
    logic [SLICE_W-1:0]   s_sum;
    logic                 s_cout;
    logic                 cin0;

`ifdef KS_WIDE_CIN_EN
    assign cin0 = cin;
`else
    assign cin0 = 1'b0;
`endif

    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int i = 0; i < NUM_SLICES; i++) begin
            if (cnt == CW'(i)) begin
                a_sl = a_r[i*SLICE_W +: SLICE_W];
                b_sl = b_r[i*SLICE_W +: SLICE_W];
            end
        end
    end

    ks_add16 u_add (
        .a    (a_sl),
        .b    (b_sl),
        .cin  (carry),
        .sum  (s_sum),
        .cout (s_cout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_r       <= '0;
            b_r       <= '0;
            cnt       <= '0;
            carry     <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r      <= a;
                        b_r      <= b;
                        cnt      <= '0;
                        carry    <= cin0;
                        cout     <= 1'b0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    for (int i = 0; i < NUM_SLICES; i++) begin
                        if (cnt == CW'(i)) begin
                            sum[i*SLICE_W +: SLICE_W] <= s_sum;
                        end
                    end
                    carry <= s_cout;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CW'(NUM_SLICES - 1)) begin
                        cout      <= s_cout;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ks_wide_seq_adder.sv
// Self-checking bench for ks_wide_seq_adder: directed/random vector table plus corner sequences.
module tb_ks_wide_seq_adder;

    localparam int NS = 4;
    localparam int W  = 16 * NS;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin_v;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ks_wide_seq_adder #(.NUM_SLICES(NS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
`ifdef KS_WIDE_CIN_EN
        .cin       (cin_v),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        int           hold;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
    } vec_t;

    vec_t vecs[$];

    // Reference: plain (W+1)-bit arithmetic.
    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        logic [W:0] r;
`ifdef KS_WIDE_CIN_EN
        r = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
`else
        r = {1'b0, x} + {1'b0, y};
`endif
        return r;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                           input int hold, input logic [W-1:0] es, input logic ec);
        vec_t v;
        v.a = x; v.b = y; v.cin = c; v.hold = hold; v.exp_sum = es; v.exp_cout = ec;
        vecs.push_back(v);
    endtask

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, input int hold,
                          output logic [W-1:0] rs, output logic rc, output int lat);
        int n;
        logic [W-1:0] held;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("in_ready_before_op", {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1; a = x; b = y; cin_v = c;
        @(posedge clk); #1;
        in_valid = 1'b0; a = ~x; b = ~y; cin_v = ~c;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        rs = sum; rc = cout; held = sum;
        for (int k = 0; k < hold; k++) begin
            in_valid = 1'b1; a = 64'h1234_5678_9ABC_DEF0; b = 64'h1;
            @(negedge clk);
            chk("hold_sum", sum, held);
            chk("hold_out_valid", {63'd0, out_valid}, 64'd1);
            chk("hold_in_ready", {63'd0, in_ready}, 64'd0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    logic [W-1:0] rs;
    logic         rc;
    int           lat;
    logic [W:0]   m;
    logic [W-1:0] ra, rb;
    logic [W:0]   exp_q[$];
    int           acc_cyc[3];

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin_v = 1'b0;
        add_vec(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 0, 64'h0000_0000_0001_0000, 1'b0);
        add_vec(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 0, 64'h0, 1'b1);
        add_vec(64'd7890, 64'd31435, 1'b0, 3, 64'd39325, 1'b0);
        add_vec(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 0, 64'h0, 1'b1);
`ifdef KS_WIDE_CIN_EN
        add_vec(64'hFFFF_FFFF_FFFF_FFFE, 64'h0, 1'b1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        add_vec(64'hFFFF_FFFF_FFFF_FFFE, 64'h1, 1'b1, 0, 64'h0, 1'b1);
`endif
        for (int i = 0; i < 6; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
`ifdef KS_WIDE_CIN_EN
            cin_v = 1'($urandom_range(1));
`endif
            m = model(ra, rb, cin_v);
            add_vec(ra, rb, cin_v, 0, m[W-1:0], m[W]);
        end
        cin_v = 1'b0;

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
        chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset_sum", sum, 64'd0);
        chk("reset_cout", {63'd0, cout}, 64'd0);
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].hold, rs, rc, lat);
            chk($sformatf("vec%0d_sum", i), rs, vecs[i].exp_sum);
            chk($sformatf("vec%0d_cout", i), {63'd0, rc}, {63'd0, vecs[i].exp_cout});
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd4);
        end

        // Reset while slice 2 is being computed.
        begin
            bit seen_valid;
            seen_valid = 1'b0;
            in_valid = 1'b1; a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'h1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            repeat (2) begin
                @(posedge clk); #1;
                if (out_valid) seen_valid = 1'b1;
            end
            rst_n = 1'b0;
            @(posedge clk); #1;
            rst_n = 1'b1;
            @(negedge clk);
            chk("rst_run_in_ready", {63'd0, in_ready}, 64'd1);
            chk("rst_run_cout", {63'd0, cout}, 64'd0);
            repeat (8) begin
                @(negedge clk);
                if (out_valid) seen_valid = 1'b1;
            end
            chk("rst_run_no_out_valid", {63'd0, seen_valid}, 64'd0);
            @(posedge clk); #1;
            run_op(64'd10, 64'd21, 1'b0, 0, rs, rc, lat);
            chk("post_rst_sum", rs, 64'd31);
            chk("post_rst_cout", {63'd0, rc}, 64'd0);
        end

        // Back-to-back throughput with both handshakes held high.
        begin
            int cyc, accepted, got;
            logic [W:0] e;
            cyc = 0; accepted = 0; got = 0;
            @(posedge clk); #1;
            out_ready = 1'b1;
            in_valid = 1'b1; a = {$urandom, $urandom}; b = {$urandom, $urandom}; cin_v = 1'b0;
            while ((accepted < 3 || got < 3) && cyc < 80) begin
                bit just_acc;
                just_acc = 1'b0;
                @(negedge clk);
                if (in_valid && in_ready) begin
                    acc_cyc[accepted] = cyc;
                    exp_q.push_back(model(a, b, cin_v));
                    accepted++;
                    just_acc = 1'b1;
                end
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("b2b_unexpected_result", {63'd0, out_valid}, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk($sformatf("b2b%0d_sum", got), sum, e[W-1:0]);
                        chk($sformatf("b2b%0d_cout", got), {63'd0, cout}, {63'd0, e[W]});
                        got++;
                    end
                end
                @(posedge clk); #1;
                cyc++;
                if (accepted >= 3) in_valid = 1'b0;
                else if (just_acc) begin
                    a = {$urandom, $urandom}; b = {$urandom, $urandom};
                end
            end
            chk("b2b_accepted", 64'(accepted), 64'd3);
            chk("b2b_results", 64'(got), 64'd3);
            if (accepted == 3) begin
                chk("b2b_gap01", 64'(acc_cyc[1] - acc_cyc[0]), 64'd6);
                chk("b2b_gap12", 64'(acc_cyc[2] - acc_cyc[1]), 64'd6);
            end
            out_ready = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
